// File: rtl/elite_spi_pkg.sv
// Shared types and constants for the elite_spi_rx SPI byte receiver.
// Optional MISO echo is built only when ELITE_SPI_ECHO_EN is defined.
package elite_spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/elite_sync.sv
// N-stage single-bit synchronizer with a configurable reset level.
// Used for every asynchronous SPI input before it reaches any logic.
module elite_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= {N{RST_VAL}};
    else     ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/elite_spi_rx.sv
// SPI mode-0 byte receiver feeding the 7-segment display stage.
// Define ELITE_SPI_ECHO_EN to echo the previous byte on SPI_MISO.
module elite_spi_rx
  import elite_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              Reset_SPI,
  input  logic              SPI_SCLK,
  input  logic              SPI_CS_N,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [BYTE_W-1:0] Elite_7Seg_Disp_Word,
  output logic              Elite_7Seg_Set_Flag,
  output logic              Spi_Frame_Err
);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d;
  logic sclk_rise, sclk_fall;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;

  logic [SYNC_STAGES-1:0] rdy;
  logic                   armed;

  elite_sync #(.N(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk (
    .clk (CLOCK_50),
    .rst (Reset_SPI),
    .d   (SPI_SCLK),
    .q   (sclk_s)
  );

  elite_sync #(.N(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_cs_n (
    .clk (CLOCK_50),
    .rst (Reset_SPI),
    .d   (SPI_CS_N),
    .q   (cs_n_s)
  );

  elite_sync #(.N(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_mosi (
    .clk (CLOCK_50),
    .rst (Reset_SPI),
    .d   (SPI_MOSI),
    .q   (mosi_s)
  );

  function automatic logic [BYTE_W-1:0] shift_in(
    input logic [BYTE_W-1:0] w,
    input logic              b
  );
    return MSB_FIRST ? {w[BYTE_W-2:0], b} : {b, w[BYTE_W-1:1]};
  endfunction

  always_ff @(posedge CLOCK_50 or posedge Reset_SPI) begin
    if (Reset_SPI) sclk_d <= SCLK_IDLE;
    else           sclk_d <= sclk_s;
  end

  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;

  // After reset the CS_N synchronizer still shows its idle level; only
  // arm once real CS_N has been seen high, so a frame already in
  // progress at release is skipped until the next CS_N fall.
  always_ff @(posedge CLOCK_50 or posedge Reset_SPI) begin
    if (Reset_SPI) begin
      rdy   <= '0;
      armed <= 1'b0;
    end else begin
      rdy <= {rdy[SYNC_STAGES-2:0], 1'b1};
      if (rdy[SYNC_STAGES-1] && cs_n_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset_SPI) begin
    if (Reset_SPI) begin
      state                <= IDLE;
      bit_cnt              <= 3'd0;
      shreg                <= '0;
      Elite_7Seg_Disp_Word <= '0;
      Elite_7Seg_Set_Flag  <= 1'b0;
      Spi_Frame_Err        <= 1'b0;
    end else begin
      Elite_7Seg_Set_Flag <= 1'b0;
      Spi_Frame_Err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (armed && !cs_n_s) begin
            state   <= SHIFT;
            bit_cnt <= 3'd0;
          end
        end
        SHIFT: begin
          // A completing edge wins over a simultaneous CS_N rise.
          if (sclk_rise && bit_cnt == 3'd7) begin
            shreg   <= shift_in(shreg, mosi_s);
            bit_cnt <= bit_cnt + 3'd1;
            state   <= LOAD;
          end else if (cs_n_s) begin
            Spi_Frame_Err <= (bit_cnt != 3'd0);
            shreg         <= '0;
            bit_cnt       <= 3'd0;
            state         <= IDLE;
          end else if (sclk_rise) begin
            shreg   <= shift_in(shreg, mosi_s);
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        LOAD: begin
          Elite_7Seg_Disp_Word <= shreg;
          Elite_7Seg_Set_Flag  <= 1'b1;
          state                <= cs_n_s ? IDLE : SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ELITE_SPI_ECHO_EN
  logic [BYTE_W-1:0] tx_sr;
  logic              miso_q;

  function automatic logic first_bit(input logic [BYTE_W-1:0] w);
    return MSB_FIRST ? w[BYTE_W-1] : w[0];
  endfunction

  function automatic logic [BYTE_W-1:0] shift_out(
    input logic [BYTE_W-1:0] w
  );
    return MSB_FIRST ? {w[BYTE_W-2:0], 1'b0} : {1'b0, w[BYTE_W-1:1]};
  endfunction

  // Bit 0 of each byte is presented at frame start or at LOAD, so the
  // falling edge that follows the 8th rise (count back at 0) must not shift.
  always_ff @(posedge CLOCK_50 or posedge Reset_SPI) begin
    if (Reset_SPI) begin
      tx_sr  <= '0;
      miso_q <= 1'b0;
    end else if (state == IDLE && armed && !cs_n_s) begin
      tx_sr  <= Elite_7Seg_Disp_Word;
      miso_q <= first_bit(Elite_7Seg_Disp_Word);
    end else if (state == LOAD) begin
      tx_sr  <= shreg;
      miso_q <= first_bit(shreg);
    end else if (state == SHIFT && !cs_n_s && sclk_fall
                 && bit_cnt != 3'd0) begin
      tx_sr  <= shift_out(tx_sr);
      miso_q <= first_bit(shift_out(tx_sr));
    end
  end

  assign SPI_MISO = miso_q;
`else
  assign SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_elite_spi_rx.sv
// Scoreboard bench for elite_spi_rx: MSB-first and LSB-first instances
// share one SPI bus; expected bytes are queued as they are driven.
module tb_elite_spi_rx;

  logic       CLOCK_50  = 1'b0;
  logic       Reset_SPI = 1'b1;
  logic       SPI_SCLK  = 1'b0;
  logic       SPI_CS_N  = 1'b1;
  logic       SPI_MOSI  = 1'b0;
  logic       miso_m, miso_l;
  logic       flag_m, flag_l;
  logic       err_m, err_l;
  logic [7:0] disp_m, disp_l;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt_m = 0;
  int err_cnt_l = 0;
  int exp_err = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic [7:0] exp_m = 8'h00;
  logic [7:0] exp_l = 8'h00;
  logic       pflag_m = 1'b0;
  logic       pflag_l = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  elite_spi_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
    .CLOCK_50             (CLOCK_50),
    .Reset_SPI            (Reset_SPI),
    .SPI_SCLK             (SPI_SCLK),
    .SPI_CS_N             (SPI_CS_N),
    .SPI_MOSI             (SPI_MOSI),
    .SPI_MISO             (miso_m),
    .Elite_7Seg_Disp_Word (disp_m),
    .Elite_7Seg_Set_Flag  (flag_m),
    .Spi_Frame_Err        (err_m)
  );

  elite_spi_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
    .CLOCK_50             (CLOCK_50),
    .Reset_SPI            (Reset_SPI),
    .SPI_SCLK             (SPI_SCLK),
    .SPI_CS_N             (SPI_CS_N),
    .SPI_MOSI             (SPI_MOSI),
    .SPI_MISO             (miso_l),
    .Elite_7Seg_Disp_Word (disp_l),
    .Elite_7Seg_Set_Flag  (flag_l),
    .Spi_Frame_Err        (err_l)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always @(negedge CLOCK_50) begin
    if (flag_m) begin
      chk("flag_m_width", {31'd0, pflag_m}, 32'd0);
      if (q_m.size() == 0) chk("flag_m_spurious", 32'd1, 32'd0);
      else chk("disp_m", {24'd0, disp_m}, {24'd0, q_m.pop_front()});
    end
    if (flag_l) begin
      chk("flag_l_width", {31'd0, pflag_l}, 32'd0);
      if (q_l.size() == 0) chk("flag_l_spurious", 32'd1, 32'd0);
      else chk("disp_l", {24'd0, disp_l}, {24'd0, q_l.pop_front()});
    end
    if (err_m) err_cnt_m++;
    if (err_l) err_cnt_l++;
    pflag_m = flag_m;
    pflag_l = flag_l;
  end

  task automatic send_bits(
    input logic [7:0] b,
    input int         n,
    input bit         cs_last
  );
    logic [7:0] pm, pl, gm, gl;
    pm = exp_m;
    pl = exp_l;
    gm = 8'h00;
    gl = 8'h00;
    for (int i = 0; i < n; i++) begin
      SPI_MOSI = b[7-i];
      #80;
      gm[7-i] = miso_m;
      gl[i]   = miso_l;
      if (n == 8 && i == 7) begin
        q_m.push_back(b);
        q_l.push_back(rev8(b));
        exp_m = b;
        exp_l = rev8(b);
      end
      SPI_SCLK = 1'b1;
      if (cs_last && i == n - 1) SPI_CS_N = 1'b1;
      #80;
      SPI_SCLK = 1'b0;
    end
    if (n == 8) begin
`ifdef ELITE_SPI_ECHO_EN
      chk("echo_m", {24'd0, gm}, {24'd0, pm});
      chk("echo_l", {24'd0, gl}, {24'd0, pl});
`else
      chk("miso_m", {24'd0, gm}, 32'd0);
      chk("miso_l", {24'd0, gl}, 32'd0);
`endif
    end
  endtask

  task automatic cs_lo();
    SPI_CS_N = 1'b0;
    #100;
  endtask

  task automatic cs_hi(input string tag);
    #80;
    SPI_CS_N = 1'b1;
    #200;
    chk({tag, "_hold_m"}, {24'd0, disp_m}, {24'd0, exp_m});
    chk({tag, "_hold_l"}, {24'd0, disp_l}, {24'd0, exp_l});
    chk({tag, "_err_m"}, err_cnt_m, exp_err);
    chk({tag, "_err_l"}, err_cnt_l, exp_err);
  endtask

  initial begin
    #100;
    chk("rst_disp_m", {24'd0, disp_m}, 32'd0);
    chk("rst_flag_m", {31'd0, flag_m}, 32'd0);
    chk("rst_err_m", {31'd0, err_m}, 32'd0);
    chk("rst_miso_m", {31'd0, miso_m}, 32'd0);
    Reset_SPI = 1'b0;
    #200;

    cs_lo();
    send_bits(8'hA5, 8, 1'b0);
    cs_hi("a5");

    cs_lo();
    send_bits(8'h3C, 8, 1'b0);
    send_bits(8'hF0, 8, 1'b0);
    cs_hi("3c_f0");

    cs_lo();
    send_bits(8'hFF, 5, 1'b0);
    exp_err++;
    cs_hi("partial");
    chk("partial_disp", {24'd0, disp_m}, 32'hF0);

    cs_lo();
    send_bits(8'h11, 8, 1'b0);
    cs_hi("11");

    cs_lo();
    send_bits(8'h5A, 8, 1'b1);
    cs_hi("cs_at_8th");

    cs_lo();
    send_bits(8'h77, 4, 1'b0);
    #20;
    Reset_SPI = 1'b1;
    #1;
    chk("arst_disp_m", {24'd0, disp_m}, 32'd0);
    chk("arst_disp_l", {24'd0, disp_l}, 32'd0);
    chk("arst_flag", {30'd0, flag_m, flag_l}, 32'd0);
    chk("arst_err", {30'd0, err_m, err_l}, 32'd0);
    chk("arst_miso", {30'd0, miso_m, miso_l}, 32'd0);
    exp_m = 8'h00;
    exp_l = 8'h00;
    #19;
    SPI_CS_N = 1'b1;
    #100;
    Reset_SPI = 1'b0;
    #200;

    cs_lo();
    send_bits(8'h42, 8, 1'b0);
    cs_hi("42");

    cs_lo();
    send_bits(8'h81, 8, 1'b0);
    send_bits(8'h00, 8, 1'b0);
    cs_hi("81_00");

    cs_lo();
    send_bits(8'h80, 8, 1'b0);
    cs_hi("lsb");
    chk("lsb_word", {24'd0, disp_l}, 32'h01);

    cs_lo();
    for (int k = 0; k < 3; k++)
      send_bits(8'($urandom_range(0, 255)), 8, 1'b0);
    cs_hi("rand");

    for (int k = 0; k < 8; k++) begin
      SPI_MOSI = 1'($urandom_range(0, 1));
      #80;
      SPI_SCLK = 1'b1;
      #80;
      SPI_SCLK = 1'b0;
    end
    #200;
    chk("cs_high_ign_m", {24'd0, disp_m}, {24'd0, exp_m});
    chk("cs_high_err", err_cnt_m, exp_err);

    chk("q_m_empty", q_m.size(), 32'd0);
    chk("q_l_empty", q_l.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
